// File: rtl/mii_tx_scheduler_pkg.sv
// Shared definitions for the MII transmit scheduler:
// FSM state encoding and default widths.
package mii_tx_scheduler_pkg;

    localparam int DEF_LEN_W   = 10;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_IFG_CYC = 24;
    localparam int CNT_W       = 13;

    // Gray-style walk: each forward transition flips one bit
    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_ISSUE     = 3'b001,
        ST_WAIT_BUSY = 3'b011,
        ST_WAIT_DONE = 3'b010,
        ST_GAP       = 3'b110
    } state_t;

endpackage

// File: rtl/mii_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester
// at or after the pointer wins.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] k;

    always_comb begin
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[k]) begin
                any = 1'b1;
                idx = k;
            end
        end
    end

    assign onehot = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/mii_tx_scheduler.sv
// Shares one MII frame sender among N_REQ requesters:
// round-robin grant, length check, gap and timeout.
module mii_tx_scheduler
    import mii_tx_scheduler_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int MIN_LEN     = 30,
    parameter int MAX_LEN     = 759,
    parameter int IFG_CYC     = DEF_IFG_CYC,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    i_clk_125m,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*LEN_W-1:0]  i_len,
    input  logic [N_REQ*ADDR_W-1:0] i_addr,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [N_REQ-1:0]        o_done,
    output logic [N_REQ-1:0]        o_err,
    output logic                    o_sendIrq,
    output logic [LEN_W-1:0]        o_length,
    output logic [ADDR_W-1:0]       o_rd_addr,
    input  logic                    i_sendIdl,
    input  logic                    i_sendDn,
    output logic                    o_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IFG_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    state_t state, state_n;

    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic [IDX_W-1:0]  ptr, ptr_n, cur, cur_n;
    logic [N_REQ-1:0]  win_oh, cur_oh;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;
    logic [LEN_W-1:0]  sel_len, len_n;
    logic [ADDR_W-1:0] sel_addr, addr_n;
    logic              len_ok, dn_q, dn_rise, to_hit;
    logic [N_REQ-1:0]  gnt_n, done_n, err_n;
    logic              irq_n;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (i_req),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    assign sel_len  = i_len[int'(win_idx)*LEN_W +: LEN_W];
    assign sel_addr = i_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    assign len_ok   = (sel_len >= LEN_W'(MIN_LEN)) &&
                      (sel_len <= LEN_W'(MAX_LEN));
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign to_hit   = (cnt_inc == TO_LAST);
    assign dn_rise  = i_sendDn & ~dn_q;
    assign cur_oh   = N_REQ'(1) << cur;
    assign o_busy   = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        cur_n   = cur;
        len_n   = o_length;
        addr_n  = o_rd_addr;
        gnt_n   = '0;
        done_n  = '0;
        err_n   = '0;
        irq_n   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (win_any && i_sendIdl) begin
                    ptr_n = (win_idx == IDX_LAST) ?
                            '0 : win_idx + IDX_W'(1);
                    cur_n = win_idx;
                    if (!len_ok) begin
                        err_n = win_oh;
                    end else begin
                        state_n = ST_ISSUE;
                        len_n   = sel_len;
                        addr_n  = sel_addr;
                        gnt_n   = win_oh;
                        irq_n   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_n   = '0;
                state_n = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                cnt_n = cnt_inc;
                if (to_hit) begin
                    err_n   = cur_oh;
                    cnt_n   = '0;
                    state_n = ST_GAP;
                end else if (!i_sendIdl) begin
                    state_n = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                cnt_n = cnt_inc;
                // a completion edge beats a same-cycle timeout
                if (dn_rise) begin
                    done_n  = cur_oh;
                    cnt_n   = '0;
                    state_n = ST_GAP;
                end else if (to_hit) begin
                    err_n   = cur_oh;
                    cnt_n   = '0;
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_125m) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ptr       <= '0;
            cur       <= '0;
            dn_q      <= 1'b0;
            o_gnt     <= '0;
            o_done    <= '0;
            o_err     <= '0;
            o_sendIrq <= 1'b0;
            o_length  <= '0;
            o_rd_addr <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            cur       <= cur_n;
            dn_q      <= i_sendDn;
            o_gnt     <= gnt_n;
            o_done    <= done_n;
            o_err     <= err_n;
            o_sendIrq <= irq_n;
            o_length  <= len_n;
            o_rd_addr <= addr_n;
        end
    end

endmodule

// File: tb/tb_mii_tx_scheduler.sv
// Self-checking bench for mii_tx_scheduler: directed
// corner cases plus randomized frames against a model.
module tb_mii_tx_scheduler;

    localparam int N   = 2;
    localparam int LW  = 10;
    localparam int AW  = 10;
    localparam int IFG = 24;
    localparam int TO  = 4096;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_req;
    logic [N*LW-1:0] i_len;
    logic [N*AW-1:0] i_addr;
    logic [N-1:0]    o_gnt, o_done, o_err;
    logic            o_sendIrq, o_busy;
    logic [LW-1:0]   o_length;
    logic [AW-1:0]   o_rd_addr;
    logic            i_sendIdl, i_sendDn;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr_m   = 0;
    int grant_log[$];

    always #4 clk = ~clk;

    mii_tx_scheduler dut (
        .i_clk_125m (clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_len      (i_len),
        .i_addr     (i_addr),
        .o_gnt      (o_gnt),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_sendIrq  (o_sendIrq),
        .o_length   (o_length),
        .o_rd_addr  (o_rd_addr),
        .i_sendIdl  (i_sendIdl),
        .i_sendDn   (i_sendDn),
        .o_busy     (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [LW-1:0] pick_len();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return LW'(29);
            1: return LW'(30);
            2: return LW'(759);
            3: return LW'(760);
            4: return LW'($urandom_range(0, 29));
            5: return LW'($urandom_range(760, 1023));
            default: return LW'($urandom_range(30, 759));
        endcase
    endfunction

    // mode 0: sender completes after dly cycles
    // mode 1: sender never leaves idle (timeout)
    // mode 2: done edge lands on the timeout cycle
    // mode 3: sendDn already high before WAIT_DONE
    task automatic frame(input logic [N-1:0] req,
                         input logic [N*LW-1:0] lens,
                         input logic [N*AW-1:0] addrs,
                         input int mode, input int dly,
                         input int gate, input bit hold);
        int w, bad, lat, g, last;
        logic [LW-1:0] lw;
        logic [AW-1:0] aw;
        bit ok;
        i_req  = req;
        i_len  = lens;
        i_addr = addrs;
        if (gate > 0) begin
            i_sendIdl = 1'b0;
            bad = 0;
            repeat (gate) begin
                step();
                if (o_sendIrq || o_gnt != 0 || o_busy || o_err != 0)
                    bad++;
            end
            check("gate_hold", 32'(bad), 0);
            i_sendIdl = 1'b1;
        end
        w = -1;
        for (int off = 0; off < N; off++) begin
            int k;
            k = (ptr_m + off) % N;
            if (w < 0 && req[k]) w = k;
        end
        lw = lens[w*LW +: LW];
        aw = addrs[w*AW +: AW];
        ok = (lw >= 30) && (lw <= 759);
        ptr_m = (w + 1) % N;
        step();
        if (!ok) begin
            check("rej_err", 32'(o_err), 32'(1 << w));
            check("rej_irq", 32'({o_sendIrq, o_gnt}), 0);
            check("rej_busy", 32'(o_busy), 0);
            i_req = '0;
            step();
            check("rej_pulse", 32'(o_err), 0);
            return;
        end
        check("irq", 32'(o_sendIrq), 1);
        check("gnt", 32'(o_gnt), 32'(1 << w));
        check("length", 32'(o_length), 32'(lw));
        check("rd_addr", 32'(o_rd_addr), 32'(aw));
        grant_log.push_back(w);
        if (!hold) i_req = '0;
        bad = 0;
        lat = $urandom_range(1, 4);
        last = (mode == 0) ? lat + dly : TO - 1;
        for (int i = 1; i <= last; i++) begin
            step();
            if (o_done != 0 || o_err != 0 || o_gnt != 0 ||
                o_sendIrq || !o_busy)
                bad++;
            case (mode)
                0: begin
                    if (i == lat) i_sendIdl = 1'b0;
                    if (i == last) i_sendDn = 1'b1;
                end
                2: begin
                    if (i == 1) i_sendIdl = 1'b0;
                    if (i == last) i_sendDn = 1'b1;
                end
                3: begin
                    if (i == 1) i_sendDn = 1'b1;
                    if (i == 2) i_sendIdl = 1'b0;
                end
                default: ;
            endcase
        end
        check("wait_quiet", 32'(bad), 0);
        step();
        if (mode == 0 || mode == 2) begin
            check("done", 32'(o_done), 32'(1 << w));
            check("no_err", 32'(o_err), 0);
        end else begin
            check("timeout_err", 32'(o_err), 32'(1 << w));
            check("no_done", 32'(o_done), 0);
        end
        check("len_hold", 32'(o_length), 32'(lw));
        i_sendIdl = 1'b1;
        i_sendDn  = 1'b0;
        g = 0;
        while (o_busy && g < 100) begin
            step();
            g++;
        end
        check("gap_len", 32'(g), IFG);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*LW-1:0] lens;
        logic [N*AW-1:0] addrs;
        int bad;
        i_rst     = 1'b1;
        i_req     = '0;
        i_len     = '0;
        i_addr    = '0;
        i_sendIdl = 1'b1;
        i_sendDn  = 1'b0;
        repeat (3) step();
        check("rst_outs", 32'({o_gnt, o_done, o_err, o_sendIrq,
                               o_length, o_rd_addr, o_busy}), 0);
        i_rst = 1'b0;
        step();
        check("post_rst_busy", 32'(o_busy), 0);

        // round-robin with both requests held
        lens  = {LW'(64), LW'(64)};
        addrs = {AW'(10'h200), AW'(10'h100)};
        grant_log.delete();
        for (int i = 0; i < 4; i++)
            frame(2'b11, lens, addrs, 0, 20, 0, 1'b1);
        i_req = '0;
        for (int i = 0; i < 4; i++)
            check("rr_seq", 32'(grant_log[i]), 32'(i % 2));

        // single issue, minimum length
        frame(2'b01, {LW'(100), LW'(30)}, {AW'(0), AW'(10'h040)},
              0, 200, 0, 1'b0);

        // length rejects on requester 1
        frame(2'b10, {LW'(29), LW'(64)}, '0, 0, 0, 0, 1'b0);
        frame(2'b10, {LW'(760), LW'(64)}, '0, 0, 0, 0, 1'b0);
        frame(2'b10, {LW'(759), LW'(64)}, '0, 0, 5, 0, 1'b0);

        // idle gating
        frame(2'b01, {LW'(64), LW'(64)}, {AW'(3), AW'(7)},
              0, 10, 6, 1'b0);

        // timeouts
        frame(2'b01, {LW'(64), LW'(64)}, '0, 1, 0, 0, 1'b0);
        frame(2'b10, {LW'(64), LW'(64)}, '0, 2, 0, 0, 1'b0);
        frame(2'b11, {LW'(64), LW'(64)}, '0, 3, 0, 0, 1'b0);

        // randomized frames
        for (int i = 0; i < 20; i++) begin
            lens  = {pick_len(), pick_len()};
            addrs = {AW'($urandom), AW'($urandom)};
            frame(N'($urandom_range(1, 3)), lens, addrs, 0,
                  $urandom_range(1, 300),
                  ($urandom_range(0, 3) == 0) ? 3 : 0, 1'b0);
        end

        // reset in the middle of WAIT_DONE
        i_req = 2'b10;
        i_len = {LW'(64), LW'(64)};
        step();
        i_req = '0;
        step();
        i_sendIdl = 1'b0;
        repeat (3) step();
        i_rst = 1'b1;
        bad = 0;
        repeat (3) begin
            step();
            if ({o_gnt, o_done, o_err, o_sendIrq, o_length,
                 o_rd_addr, o_busy} != 0)
                bad++;
        end
        check("mid_rst_outs", 32'(bad), 0);
        i_rst     = 1'b0;
        i_sendIdl = 1'b1;
        i_sendDn  = 1'b1;
        ptr_m     = 0;
        step();
        check("rst_irq", 32'(o_sendIrq), 0);
        bad = 0;
        repeat (30) begin
            step();
            if (o_done != 0 || o_err != 0 || o_busy) bad++;
        end
        check("rst_silent", 32'(bad), 0);
        i_sendDn = 1'b0;
        frame(2'b11, {LW'(64), LW'(64)}, '0, 0, 15, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
